// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM access controller: FSM state encoding,
// default data/address widths and the statistics counter width.
package ram_ctrl_pkg;

   localparam int DEFAULT_DATA_WIDTH    = 16;
   localparam int DEFAULT_ADDRESS_WIDTH = 8;
   localparam int STAT_WIDTH            = 16;

   // IDLE accepts requests; RD_ISSUE is the cycle Read_Enable is high;
   // RSP_HOLD presents the response until the consumer takes it.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_ISSUE = 2'd1,
      RSP_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous load, used for the access
// statistics of ram_access_ctrl. Holds at all-ones once reached.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count
);

   // Load has priority; otherwise count up on enable and stop at the maximum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (en && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/ram_access_ctrl.sv
// Request/response front end for a dual-port RAM with registered read data.
// Writes are posted (one per cycle, no response); reads take two cycles
// from acceptance to Rsp_Valid and hold the response until Rsp_Ready.
// Optional feature: define RAM_CTRL_STATS_EN to add saturating
// Read_Count / Write_Count outputs.
//
// Handshake semantics: a request transfers on a rising edge where
// Req_Valid and Req_Ready are both high; a response transfers on a rising
// edge where Rsp_Valid and Rsp_Ready are both high. Once raised, Rsp_Valid
// and Rsp_Data stay stable until that transfer; Req_Ready is high only
// in IDLE, so no request is taken while a read is outstanding.
module ram_access_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
   input  logic                     Clock,
   input  logic                     Reset_n,
   // request channel
   input  logic                     Req_Valid,
   output logic                     Req_Ready,
   input  logic                     Req_Write,
   input  logic [ADDRESS_WIDTH-1:0] Req_Address,
   input  logic [DATA_WIDTH-1:0]    Req_Data,
   // response channel
   output logic                     Rsp_Valid,
   input  logic                     Rsp_Ready,
   output logic [DATA_WIDTH-1:0]    Rsp_Data,
   // RAM write port
   output logic [ADDRESS_WIDTH-1:0] write_address,
   output logic                     Write_Enable,
   output logic [DATA_WIDTH-1:0]    DATA_WRITE,
   // RAM read port
   output logic [ADDRESS_WIDTH-1:0] read_address,
   output logic                     Read_Enable,
   input  logic [DATA_WIDTH-1:0]    DATA_READ,
   // FSM state for observation
   output logic [1:0]               fsm_state
`ifdef RAM_CTRL_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0]    Read_Count,
   output logic [STAT_WIDTH-1:0]    Write_Count
`endif
);

   state_t                   state;
   logic                     ready_q;
   logic                     we_q;
   logic [ADDRESS_WIDTH-1:0] waddr_q;
   logic [DATA_WIDTH-1:0]    wdata_q;
   logic                     re_q;
   logic [ADDRESS_WIDTH-1:0] raddr_q;
   logic                     rsp_valid_q;

   logic                     accept;
   logic                     accept_wr;
   logic                     accept_rd;

   assign accept    = Req_Valid && ready_q;
   assign accept_wr = accept && Req_Write;
   assign accept_rd = accept && !Req_Write;

   // Controller FSM; every output it drives is a register updated here.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= IDLE;
         ready_q     <= 1'b1;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         re_q        <= 1'b0;
         raddr_q     <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         // Enables are single-cycle pulses unless re-armed below.
         we_q <= 1'b0;
         re_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_wr) begin
                  // Posted write: stay in IDLE so the next write can follow.
                  we_q    <= 1'b1;
                  waddr_q <= Req_Address;
                  wdata_q <= Req_Data;
               end else if (accept_rd) begin
                  re_q    <= 1'b1;
                  raddr_q <= Req_Address;
                  ready_q <= 1'b0;
                  state   <= RD_ISSUE;
               end
            end
            RD_ISSUE: begin
               // RAM captures DATA_READ at this edge; present it next cycle.
               rsp_valid_q <= 1'b1;
               state       <= RSP_HOLD;
            end
            RSP_HOLD: begin
               // Read_Enable stays low here, so DATA_READ cannot change.
               if (Rsp_Ready) begin
                  rsp_valid_q <= 1'b0;
                  ready_q     <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               ready_q     <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign Req_Ready     = ready_q;
   assign Rsp_Valid     = rsp_valid_q;
   assign Rsp_Data      = DATA_READ;
   assign write_address = waddr_q;
   assign Write_Enable  = we_q;
   assign DATA_WRITE    = wdata_q;
   assign read_address  = raddr_q;
   assign Read_Enable   = re_q;
   assign fsm_state     = state;

`ifdef RAM_CTRL_STATS_EN
   sat_counter #(
      .WIDTH (STAT_WIDTH)
   ) u_read_count (
      .clk        (Clock),
      .rst_n      (Reset_n),
      .en         (accept_rd),
      .load       (1'b0),
      .load_value ({STAT_WIDTH{1'b0}}),
      .count      (Read_Count)
   );

   sat_counter #(
      .WIDTH (STAT_WIDTH)
   ) u_write_count (
      .clk        (Clock),
      .rst_n      (Reset_n),
      .en         (accept_wr),
      .load       (1'b0),
      .load_value ({STAT_WIDTH{1'b0}}),
      .count      (Write_Count)
   );
`else
   // No access statistics in this build.
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural RAM (registered
// read data, held while Read_Enable is low). Inputs change 1 time unit
// after the rising edge; outputs are checked at that same point.
module tb_ram_access_ctrl;
   import ram_ctrl_pkg::*;

   localparam int DW = 16;
   localparam int AW = 8;

   logic          Clock;
   logic          Reset_n;
   logic          Req_Valid;
   logic          Req_Ready;
   logic          Req_Write;
   logic [AW-1:0] Req_Address;
   logic [DW-1:0] Req_Data;
   logic          Rsp_Valid;
   logic          Rsp_Ready;
   logic [DW-1:0] Rsp_Data;
   logic [AW-1:0] write_address;
   logic          Write_Enable;
   logic [DW-1:0] DATA_WRITE;
   logic [AW-1:0] read_address;
   logic          Read_Enable;
   logic [DW-1:0] DATA_READ;
   logic [1:0]    fsm_state;
`ifdef RAM_CTRL_STATS_EN
   logic [15:0]   Read_Count;
   logic [15:0]   Write_Count;
   logic          sc_en;
   logic          sc_load;
   logic [15:0]   sc_load_value;
   logic [15:0]   sc_count;
`endif

   int n_checks  = 0;
   int n_errors  = 0;
   int re_pulses = 0;
   int re_base;

   ram_access_ctrl #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW)
   ) dut (
      .Clock         (Clock),
      .Reset_n       (Reset_n),
      .Req_Valid     (Req_Valid),
      .Req_Ready     (Req_Ready),
      .Req_Write     (Req_Write),
      .Req_Address   (Req_Address),
      .Req_Data      (Req_Data),
      .Rsp_Valid     (Rsp_Valid),
      .Rsp_Ready     (Rsp_Ready),
      .Rsp_Data      (Rsp_Data),
      .write_address (write_address),
      .Write_Enable  (Write_Enable),
      .DATA_WRITE    (DATA_WRITE),
      .read_address  (read_address),
      .Read_Enable   (Read_Enable),
      .DATA_READ     (DATA_READ),
      .fsm_state     (fsm_state)
`ifdef RAM_CTRL_STATS_EN
      ,
      .Read_Count    (Read_Count),
      .Write_Count   (Write_Count)
`endif
   );

`ifdef RAM_CTRL_STATS_EN
   sat_counter #(.WIDTH(16)) u_sat (
      .clk        (Clock),
      .rst_n      (Reset_n),
      .en         (sc_en),
      .load       (sc_load),
      .load_value (sc_load_value),
      .count      (sc_count)
   );
`endif

   // clock
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // behavioural RAM: write and registered read on the rising edge
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge Clock) begin
      if (Write_Enable) mem[write_address] <= DATA_WRITE;
      if (Read_Enable) DATA_READ <= mem[read_address];
   end

   // count Read_Enable pulses seen by the RAM
   always @(posedge Clock) begin
      if (Read_Enable === 1'b1) re_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic drive_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      Req_Valid   = 1'b1;
      Req_Write   = w;
      Req_Address = a;
      Req_Data    = d;
   endtask

   task automatic idle_req();
      Req_Valid   = 1'b0;
      Req_Write   = 1'b0;
      Req_Address = '0;
      Req_Data    = '0;
   endtask

   // full read with Rsp_Ready already high: accept, issue, respond, idle
   task automatic do_read(input logic [AW-1:0] a);
      drive_req(1'b0, a, '0);
      tick();
      idle_req();
      tick();
      tick();
      tick();
   endtask

   initial begin
      DATA_READ = '0;
      Reset_n   = 1'b0;
      Rsp_Ready = 1'b1;
      idle_req();
`ifdef RAM_CTRL_STATS_EN
      sc_en         = 1'b0;
      sc_load       = 1'b0;
      sc_load_value = '0;
`endif

      // reset state
      tick();
      check("rst_we", Write_Enable, 0);
      check("rst_re", Read_Enable, 0);
      check("rst_rsp_valid", Rsp_Valid, 0);
      check("rst_waddr", write_address, 0);
      check("rst_wdata", DATA_WRITE, 0);
      check("rst_raddr", read_address, 0);
      check("rst_ready", Req_Ready, 1);
      check("rst_state", fsm_state, IDLE);
      @(negedge Clock);
      Reset_n = 1'b1;
      tick();

      // no acceptance without Req_Valid
      Req_Valid   = 1'b0;
      Req_Write   = 1'b1;
      Req_Address = 8'h33;
      Req_Data    = 16'h5A5A;
      tick();
      check("novalid_we", Write_Enable, 0);
      check("novalid_state", fsm_state, IDLE);
      idle_req();

      // write 0xBEEF to 0x05 then read 0x05
      drive_req(1'b1, 8'h05, 16'hBEEF);
      tick();
      check("wr_we", Write_Enable, 1);
      check("wr_addr", write_address, 8'h05);
      check("wr_data", DATA_WRITE, 16'hBEEF);
      check("wr_ready", Req_Ready, 1);
      drive_req(1'b0, 8'h05, '0);
      tick();
      idle_req();
      check("rd_we_low", Write_Enable, 0);
      check("rd_re", Read_Enable, 1);
      check("rd_addr", read_address, 8'h05);
      check("rd_issue_rsp_valid", Rsp_Valid, 0);
      check("rd_issue_ready", Req_Ready, 0);
      tick();
      check("rd_rsp_valid", Rsp_Valid, 1);
      check("rd_rsp_data", Rsp_Data, 16'hBEEF);
      check("rd_re_low", Read_Enable, 0);
      tick();
      check("rd_done_rsp_valid", Rsp_Valid, 0);
      check("rd_done_ready", Req_Ready, 1);

      // four back-to-back writes
      for (int i = 0; i < 4; i++) begin
         drive_req(1'b1, 8'(i), 16'(16'h1111 * (i + 1)));
         tick();
         check("b2b_we", Write_Enable, 1);
         check("b2b_addr", write_address, 32'(i));
         check("b2b_data", DATA_WRITE, 32'(16'h1111 * (i + 1)));
         check("b2b_ready", Req_Ready, 1);
      end
      idle_req();
      tick();
      check("b2b_we_end", Write_Enable, 0);

      // read 0x02 with Rsp_Ready low for 5 cycles
      Rsp_Ready = 1'b0;
      re_base   = re_pulses;
      drive_req(1'b0, 8'h02, '0);
      tick();
      check("hold_re", Read_Enable, 1);
      drive_req(1'b1, 8'h40, 16'hDEAD);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("hold_rsp_valid", Rsp_Valid, 1);
         check("hold_rsp_data", Rsp_Data, 16'h3333);
         check("hold_ready", Req_Ready, 0);
         check("hold_we", Write_Enable, 0);
         check("hold_re_low", Read_Enable, 0);
         if (i < 4) tick();
      end
      idle_req();
      Rsp_Ready = 1'b1;
      tick();
      check("hold_one_re", re_pulses - re_base, 1);
      check("hold_state_idle", fsm_state, IDLE);
      check("hold_done_rsp_valid", Rsp_Valid, 0);
      check("hold_done_ready", Req_Ready, 1);

      // write then immediate read of the same address
      drive_req(1'b1, 8'h10, 16'h00AA);
      tick();
      drive_req(1'b0, 8'h10, '0);
      tick();
      idle_req();
      tick();
      check("raw_rsp_valid", Rsp_Valid, 1);
      check("raw_rsp_data", Rsp_Data, 16'h00AA);
      tick();

      // reset pulse during RD_ISSUE
      drive_req(1'b0, 8'h05, '0);
      tick();
      idle_req();
      check("rstmid_re_before", Read_Enable, 1);
      check("rstmid_state_before", fsm_state, RD_ISSUE);
      #2;
      Reset_n = 1'b0;
      #1;
      check("rstmid_re", Read_Enable, 0);
      check("rstmid_rsp_valid", Rsp_Valid, 0);
      check("rstmid_state", fsm_state, IDLE);
      @(negedge Clock);
      Reset_n = 1'b1;
      tick();
      check("rstrel_ready", Req_Ready, 1);
      check("rstrel_rsp_valid", Rsp_Valid, 0);
      check("rstrel_re", Read_Enable, 0);
      drive_req(1'b1, 8'h21, 16'h0123);
      tick();
      idle_req();
      check("rstrel_we", Write_Enable, 1);
      check("rstrel_wdata", DATA_WRITE, 16'h0123);

`ifdef RAM_CTRL_STATS_EN
      // one write since reset above; two more writes and two reads
      drive_req(1'b1, 8'h22, 16'h0001);
      tick();
      drive_req(1'b1, 8'h23, 16'h0002);
      tick();
      idle_req();
      do_read(8'h22);
      do_read(8'h23);
      check("stat_write_count", Write_Count, 3);
      check("stat_read_count", Read_Count, 2);

      // saturation at 0xFFFF
      sc_load       = 1'b1;
      sc_load_value = 16'hFFFE;
      tick();
      sc_load = 1'b0;
      sc_en   = 1'b1;
      tick();
      check("sat_to_max", sc_count, 16'hFFFF);
      tick();
      sc_en = 1'b0;
      check("sat_hold_max", sc_count, 16'hFFFF);
`else
      do_read(8'h21);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // bound on total run time
   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

endmodule
